// File: rtl/pulse_tx_pkg.sv
// Shared types and defaults for the pulse transmitter symbol path.
package pulse_tx_pkg;

    localparam int TIMER_WIDTH_DEF    = 12;
    localparam int PRESCALE_WIDTH_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic                       level;
        logic [TIMER_WIDTH_DEF-1:0] duration;
    } symbol_t;

endpackage

// File: rtl/symbol_fifo2.sv
// Two-entry synchronous FIFO; flush empties it like a reset.
module symbol_fifo2 #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == 2'd2);
    assign empty   = (count_reg == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_reg[rd_ptr_reg];

    // Storage carries no reset; contents are only read while the count says valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n || flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
            if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
            unique case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/pulse_symbol_engine.sv
// Plays queued (level, duration) symbols for exact prescaled tick counts,
// optionally gating high symbols with the carrier and controlling its enable.
module pulse_symbol_engine
    import pulse_tx_pkg::*;
#(
    parameter int TIMER_WIDTH    = TIMER_WIDTH_DEF,
    parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      sys_rst_n,
    input  logic                      en,
    input  logic [PRESCALE_WIDTH-1:0] prescaler,
    input  logic                      idle_level,
    input  logic                      carrier_mode,
    input  logic                      sym_valid,
    input  logic                      sym_level,
    input  logic [TIMER_WIDTH-1:0]    sym_duration,
    output logic                      sym_ready,
    input  logic                      carrier_in,
    output logic                      carrier_en,
    output logic                      pulse_out,
    output logic                      busy,
    output logic                      done
);

    typedef struct packed {
        logic                   level;
        logic [TIMER_WIDTH-1:0] duration;
    } sym_t;

    sym_t                      push_data;
    sym_t                      head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      load;
    logic                      tick;
    logic                      sym_end;
    logic                      mark;

    state_t                    state_reg, state_next;
    logic [PRESCALE_WIDTH-1:0] pre_cnt_reg;
    logic [TIMER_WIDTH-1:0]    dur_cnt_reg;
    logic                      level_reg;
    logic                      done_reg;

    assign push_data = '{level: sym_level, duration: sym_duration};
    assign sym_ready = sys_rst_n && en && !fifo_full;
    assign push      = sym_valid && sym_ready;

    symbol_fifo2 #(
        .WIDTH($bits(sym_t))
    ) u_fifo (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .flush     (!en),
        .push      (push),
        .din       (push_data),
        .pop       (load),
        .dout      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tick    = (pre_cnt_reg == '0);
    assign sym_end = (state_reg == ST_RUN) && tick && (dur_cnt_reg == '0);
    // A symbol ending with more queued chains straight into the next one.
    assign load    = !fifo_empty && ((state_reg == ST_IDLE) || sym_end);

    always_ff @(posedge clk) begin
        if (!sys_rst_n || !en) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (!fifo_empty)          state_next = ST_RUN;
            ST_RUN:  if (sym_end && fifo_empty) state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n || !en) begin
            pre_cnt_reg <= '0;
            dur_cnt_reg <= '0;
            level_reg   <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= sym_end && fifo_empty;
            if (load) begin
                dur_cnt_reg <= head.duration;
                pre_cnt_reg <= prescaler;
                level_reg   <= head.level;
            end else if (state_reg == ST_RUN) begin
                if (!tick) begin
                    pre_cnt_reg <= pre_cnt_reg - PRESCALE_WIDTH'(1);
                end else begin
                    pre_cnt_reg <= prescaler;
                    if (dur_cnt_reg != '0) begin
                        dur_cnt_reg <= dur_cnt_reg - TIMER_WIDTH'(1);
                    end else begin
                        level_reg <= idle_level;
                    end
                end
            end else begin
                level_reg <= idle_level;
            end
        end
    end

    always_comb begin
        mark       = (state_reg == ST_RUN) && carrier_mode && level_reg;
        carrier_en = mark;
        pulse_out  = mark ? carrier_in : level_reg;
        busy       = (state_reg == ST_RUN) || !fifo_empty;
        done       = done_reg;
    end

endmodule

// File: tb/tb_pulse_symbol_engine.sv
// Directed and randomized checks of pulse_symbol_engine against a
// clock-count reference model and a behavioural carrier generator.
module tb_pulse_symbol_engine;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        en = 1'b1;
    logic [7:0]  prescaler = '0;
    logic        idle_level = 1'b0;
    logic        carrier_mode = 1'b0;
    logic        sym_valid = 1'b0;
    logic        sym_level = 1'b0;
    logic [11:0] sym_duration = '0;
    logic        sym_ready;
    logic        carrier_in = 1'b0;
    logic        carrier_en;
    logic        pulse_out;
    logic        busy;
    logic        done;

    int compared = 0;
    int mismatched = 0;

    // Reference model: symbols waiting, and the symbol playing as a remaining clock count.
    int q_lvl[$];
    int q_dur[$];
    bit m_play = 0;
    int m_rem = 0;
    bit m_lvl = 0;
    bit m_done = 0;
    int car_cnt = 0;
    bit last_acc = 0;
    int hi_cnt = 0;
    int ce_cnt = 0;
    int done_cnt = 0;

    pulse_symbol_engine dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .en           (en),
        .prescaler    (prescaler),
        .idle_level   (idle_level),
        .carrier_mode (carrier_mode),
        .sym_valid    (sym_valid),
        .sym_level    (sym_level),
        .sym_duration (sym_duration),
        .sym_ready    (sym_ready),
        .carrier_in   (carrier_in),
        .carrier_en   (carrier_en),
        .pulse_out    (pulse_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_start();
        int d;
        int l;
        d = q_dur.pop_front();
        l = q_lvl.pop_front();
        m_rem  = (d + 1) * (int'(prescaler) + 1);
        m_play = 1;
        m_lvl  = l[0];
    endtask

    task automatic model_edge(input bit acc);
        if (!sys_rst_n || !en) begin
            q_lvl.delete();
            q_dur.delete();
            m_play = 0;
            m_lvl  = 0;
            m_done = 0;
        end else begin
            m_done = 0;
            if (m_play) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (q_lvl.size() > 0) model_start();
                    else begin
                        m_play = 0;
                        m_lvl  = idle_level;
                        m_done = 1;
                    end
                end
            end else if (q_lvl.size() > 0) begin
                model_start();
            end else begin
                m_lvl = idle_level;
            end
            if (acc) begin
                q_lvl.push_back(int'(sym_level));
                q_dur.push_back(int'(sym_duration));
            end
        end
    endtask

    task automatic step();
        logic exp_ready;
        logic ce_pre;
        bit   acc;
        bit   exp_mark;
        #1;
        exp_ready = sys_rst_n && en && (q_lvl.size() < 2);
        chk("sym_ready", sym_ready, exp_ready);
        acc = sym_valid && exp_ready;
        last_acc = acc;
        ce_pre = carrier_en;
        @(posedge clk);
        model_edge(acc);
        #1;
        // Carrier generator: cleared while disabled, toggles every 2 clocks when enabled.
        if (ce_pre === 1'b1) begin
            if (car_cnt == 0) begin
                carrier_in = ~carrier_in;
                car_cnt = 1;
            end else begin
                car_cnt--;
            end
        end else begin
            car_cnt = 0;
            carrier_in = 1'b0;
        end
        #1;
        exp_mark = m_play && carrier_mode && m_lvl;
        chk("pulse_out", pulse_out, exp_mark ? carrier_in : m_lvl);
        chk("carrier_en", carrier_en, exp_mark);
        chk("busy", busy, m_play || (q_lvl.size() > 0));
        chk("done", done, m_done);
        hi_cnt   += int'(pulse_out);
        ce_cnt   += int'(carrier_en);
        done_cnt += int'(done);
    endtask

    task automatic push_sym(input bit l, input int d);
        sym_valid = 1'b1;
        sym_level = l;
        sym_duration = 12'(d);
        for (int k = 0; k < 10000; k++) begin
            step();
            if (last_acc) break;
        end
        chk("push_accepted", 32'(last_acc), 1);
        sym_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound; k++) begin
            step();
            if (busy === 1'b0) break;
        end
        chk("wait_idle", busy, 0);
        step();
    endtask

    task automatic clear_counts();
        hi_cnt = 0;
        ce_cnt = 0;
        done_cnt = 0;
    endtask

    initial begin
        // Reset state
        for (int k = 0; k < 3; k++) step();
        chk("reset_pulse", pulse_out, 0);
        sys_rst_n = 1'b1;
        step();

        // Single symbol, no carrier
        clear_counts();
        push_sym(1, 4);
        wait_idle(50);
        chk("t1_high_clocks", hi_cnt, 5);
        chk("t1_done_count", done_cnt, 1);

        // Back-to-back symbols with prescaler 3
        prescaler = 8'd3;
        clear_counts();
        push_sym(1, 2);
        push_sym(0, 1);
        push_sym(1, 0);
        wait_idle(100);
        chk("t2_high_clocks", hi_cnt, 16);
        chk("t2_done_count", done_cnt, 1);

        // Prescaler boundaries
        prescaler = 8'd255;
        clear_counts();
        push_sym(1, 0);
        wait_idle(400);
        chk("t3_presc_max", hi_cnt, 256);
        prescaler = 8'd0;
        clear_counts();
        push_sym(1, 4095);
        wait_idle(5000);
        chk("t3_dur_max", hi_cnt, 4096);

        // Carrier mode
        carrier_mode = 1'b1;
        clear_counts();
        push_sym(1, 9);
        push_sym(0, 3);
        wait_idle(100);
        chk("t4_carrier_en_clocks", ce_cnt, 10);
        chk("t4_done_count", done_cnt, 1);
        carrier_mode = 1'b0;

        // Abort with one entry queued
        prescaler = 8'd3;
        clear_counts();
        push_sym(1, 5);
        push_sym(1, 2);
        step();
        step();
        en = 1'b0;
        step();
        chk("t5_busy_after_abort", busy, 0);
        idle_level = 1'b1;
        step();
        en = 1'b1;
        for (int k = 0; k < 20; k++) step();
        chk("t5_done_count", done_cnt, 0);
        chk("t5_idle_pulse", pulse_out, 1);

        // Reset during RUN with idle_level high
        push_sym(0, 20);
        for (int k = 0; k < 4; k++) step();
        sys_rst_n = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("t6_reset_pulse", pulse_out, 0);
        sys_rst_n = 1'b1;
        step();
        chk("t6_release_pulse", pulse_out, 1);
        idle_level = 1'b0;
        step();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            sym_valid    = ($urandom_range(0, 2) != 0);
            sym_level    = 1'($urandom_range(0, 1));
            sym_duration = 12'($urandom_range(0, 5));
            en           = ($urandom_range(0, 299) != 0);
            if (!m_play && q_lvl.size() == 0) prescaler = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) carrier_mode = ~carrier_mode;
            if ($urandom_range(0, 39) == 0) idle_level = ~idle_level;
            step();
        end
        sym_valid = 1'b0;
        en = 1'b1;
        wait_idle(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pulse_symbol_engine.md
Name: pulse_symbol_engine

Overview:
Downstream consumer of the carrier generator in the pulse transmitter. Accepts a stream of (level, duration) symbols over a valid/ready handshake and buffers them in a 2-entry FIFO. Plays each symbol for an exact number of prescaled ticks. Drives the pin either directly or AND-gated with the incoming 50% carrier wave, and controls the carrier's enable so each modulated mark starts phase-aligned.

Parameters:
TIMER_WIDTH, 12, width of symbol duration field and duration counter
PRESCALE_WIDTH, 8, width of the clock prescaler value and counter

Ports:
clk  input  1  system clock
sys_rst_n  input  1  synchronous active-low reset
en  input  1  block enable; low = synchronous flush
prescaler  input  PRESCALE_WIDTH  tick = prescaler+1 clocks; sampled at each tick reload
idle_level  input  1  pin level when no symbol is playing
carrier_mode  input  1  1 = high symbols are modulated by carrier_in
sym_valid  input  1  symbol offered
sym_level  input  1  symbol output level
sym_duration  input  TIMER_WIDTH  symbol length minus one, in ticks
sym_ready  output  1  symbol accepted when sym_valid && sym_ready
carrier_in  input  1  square wave from carrier generator
carrier_en  output  1  enable to carrier generator
pulse_out  output  1  transmitter pin
busy  output  1  state is RUN or FIFO non-empty
done  output  1  one-cycle pulse when the last queued symbol completes

Behaviour:
- Clock and reset: single clock clk; reset sys_rst_n is synchronous and active-low. All state updates happen on posedge clk.
- Reset, or en low, takes priority each cycle and forces:
  - FIFO empty, state IDLE, all counters 0, level register 0, done 0.
  - Mid-symbol en deassertion aborts the symbol with no done pulse.
- Output values while reset is held:
  - sym_ready 0, carrier_en 0, busy 0, done 0.
  - pulse_out 0: the level register is forced to 0 and IDLE drives the registered level, not idle_level directly.
- After reset, in IDLE with en high, the level register loads idle_level each cycle. pulse_out follows idle_level one clock later.
- FIFO: 2 entries of {level, duration}.
  - sym_ready = en && !full. Readiness does not depend on a same-cycle pop, so there is no combinational path from pop to ready.
  - A push and a pop in the same cycle are both honoured.
  - Order is strict FIFO.
- State machine: IDLE, RUN.
- IDLE -> RUN when the FIFO is non-empty. On that edge:
  - pop the head;
  - dur_cnt <= duration;
  - pre_cnt <= prescaler;
  - level_r <= sym_level.
  - The new level appears on pulse_out the following cycle.
- RUN, each clock:
  - If pre_cnt != 0: pre_cnt <= pre_cnt - 1.
  - Else pre_cnt <= prescaler (sampled now), and:
    - if dur_cnt != 0: dur_cnt <= dur_cnt - 1;
    - else the symbol ends:
      - FIFO non-empty: pop the next symbol on the same edge, staying in RUN with no gap cycle.
      - FIFO empty: go to IDLE, level_r <= idle_level, done <= 1 for one cycle.
- Symbol length is exactly (duration+1)*(prescaler+1) clocks, with prescaler held constant.
  - duration=0 and prescaler=0 gives a 1-clock symbol.
  - Maximum length is 2^TIMER_WIDTH * 2^PRESCALE_WIDTH clocks.
  - Counters never wrap; an underflow path is unreachable.
- Output gating:
  - pulse_out = (state==RUN && carrier_mode && level_r) ? carrier_in : level_r.
  - carrier_en = state==RUN && carrier_mode && level_r (registered terms only).
  - Because the carrier generator clears its counter while disabled, each modulated mark restarts the carrier.
  - The carrier produces its first high 1 clock after carrier_en rises, so the first mark clock is low; this is accepted.
  - Consecutive high symbols keep carrier_en high, so the carrier runs continuously across the symbol boundary.
- busy is combinational from state and FIFO count.

Decomposition:
- Shared package pulse_tx_pkg:
  - symbol struct/typedef {level, duration[TIMER_WIDTH]};
  - state encoding constants ST_IDLE, ST_RUN;
  - default width constants.
- One sub-module: symbol_fifo2, a 2-entry synchronous FIFO with push, pop, full, empty and data out, taking the same clk and sys_rst_n.
- Prescaler, duration counter, state machine and output gating live in the top module.

Test Plan:
- Single symbol, no carrier: prescaler=0, idle_level=0, push {1,4} -> pulse_out high for exactly 5 clocks starting 2 clocks after acceptance, then 0; done pulses once; busy falls with done.
- Back-to-back symbols: push {1,2},{0,1},{1,0} with prescaler=3 -> high 12, low 8, high 4 clocks with no gap; sym_ready low while FIFO is full; single done at the end.
- Prescaler boundary: prescaler=255, duration=0 -> 256-clock symbol; prescaler=0, duration=4095 -> 4096-clock symbol.
- Carrier mode with a behavioural carrier (duration 2): push {1,9} -> carrier_en high for 10 clocks; pulse_out = carrier_in during them; then {0,3} -> pulse_out 0 and carrier_en 0.
- Abort: en dropped mid-symbol with 1 entry queued -> next cycle FIFO empty, state IDLE, sym_ready 0, no done; after en returns, pulse_out = idle_level and the queued entry is never played.
- Reset: sys_rst_n low during RUN with idle_level=1 -> all outputs 0 while held; after release, pulse_out goes to 1 one clock later.
